fpu_sched: RTL and testbench
============================

Name: fpu_sched

Overview:
Sequencer and two-requester arbiter for the shared floating-point ALU (add/sub/mul/div selected by a 2-bit op code, 5-bit IEEE status flags).
- Accepts operations from two independent valid/ready request ports and grants them round-robin.
- Registers the operands, holds them stable for a fixed settle latency, then presents a registered result with requester ID on a valid/ready response port.
- Keeps a sticky, software-clearable status register of all reported flags.
- Sits between the load/store front end and the FP datapath. The ALU is instantiated inside this block.

Parameters:
EXP, 8, exponent width
FRAC, 23, fraction width
WIDTH, EXP+FRAC+1, operand/result width
LAT, 2, cycles operands are held before the result is sampled (legal range 1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  WIDTH  operand A
req0_b  in  WIDTH  operand B
req0_op  in  2  00 add, 01 sub, 10 mul, 11 div
req0_rnd  in  1  round mode passed to the ALU
req1_valid, req1_ready, req1_a, req1_b, req1_op, req1_rnd  same as requester 0
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes result
rsp_id  out  1  requester that issued the result
rsp_result  out  WIDTH  result
rsp_flags  out  5  [0] inexact [1] underflow [2] overflow [3] div_by_0 [4] invalid
sticky_flags  out  5  OR of all delivered rsp_flags since reset or clear
sticky_clr  in  1  synchronous clear of sticky_flags
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst high): state=IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, sticky_flags=0, last_grant=1 (requester 0 wins first), cnt=0. Reset mid-operation discards the in-flight op; no response is produced.
- FSM states: IDLE, EXEC, RESP. One operation in flight at a time; no pipelining.
- IDLE:
  - reqN_ready is combinational and asserted only in IDLE, for the granted requester only.
  - Grant: if only one valid, grant it. If both valid, grant the one that is not last_grant.
  - On a handshake edge: latch a/b/op/rnd/id, update last_grant, cnt<=LAT-1, go to EXEC.
- EXEC:
  - Latched operands drive the ALU.
  - If cnt!=0, decrement cnt.
  - If cnt==0, latch the ALU result and flags into rsp_result/rsp_flags and go to RESP.
  - op=11 (div): the datapath has no divider. The block returns rsp_result = canonical qNaN {0, all-ones exponent, 1 followed by zeros} (0x7FC00000 at defaults) and rsp_flags=5'b10000, with the same LAT timing.
- Latency: rsp_valid rises exactly LAT clock edges after the request handshake edge.
- RESP:
  - rsp_valid=1. Result, ID and flags are held stable until rsp_ready.
  - On the handshake edge: rsp_valid<=0, go to IDLE. The next request cannot be accepted before the following cycle (minimum 2+LAT cycles per op).
- Sticky register:
  - On a response handshake: sticky_flags <= sticky_flags | rsp_flags.
  - sticky_clr alone: sticky_flags <= 0.
  - sticky_clr and response handshake in the same cycle: sticky_flags <= rsp_flags (the clear applies first, then the new flags).
- Requester inputs are ignored outside their own handshake. Deasserting valid before ready is legal, and no grant is recorded in that case.

Decomposition:
- Shared package fpu_pkg:
  - op code constants OP_ADD/OP_SUB/OP_MUL/OP_DIV
  - flag bit indices FLG_NX/FLG_UF/FLG_OF/FLG_DZ/FLG_NV
  - state enum
  - QNAN constant function of EXP/FRAC
- One natural sub-module: rr_arb2, a combinational two-way round-robin grant with last_grant input.

Test Plan:
- Add: req0 a=0x3F800000, b=0x40000000, op=00 -> after LAT=2 edges rsp_valid=1, rsp_result=0x40400000, rsp_id=0, rsp_flags=0.
- Simultaneous requests: req0 and req1 valid in the same cycle after reset.
  - req0 is granted first; req1 is granted next. Responses carry id 0 then 1.
  - A third concurrent pair grants req0 again.
- Overflow: req1 mul 0x7F7FFFFF * 0x40000000, rnd=0 -> rsp_result=0x7F800000, rsp_flags=5'b00101; after handshake sticky_flags=5'b00101.
- Div and clear: div 0x3F800000 / 0x40000000 -> rsp_result=0x7FC00000, rsp_flags=5'b10000. Assert sticky_clr in the same cycle as the response handshake -> sticky_flags=5'b10000.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp outputs are stable, both reqN_ready=0, busy=1. Release -> one handshake, then IDLE.
- Reset mid-op: assert rst while in EXEC -> rsp_valid=0 and busy=0 immediately (async); no response after release; sticky_flags=0.

Source files
------------

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared op codes, flag indices, FSM states and NaN constant for fpu_sched
package fpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int FLG_NX = 0;
  localparam int FLG_UF = 1;
  localparam int FLG_OF = 2;
  localparam int FLG_DZ = 3;
  localparam int FLG_NV = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  function automatic logic [63:0] qnan(input int exp_w, input int frac_w);
    return (((64'd1 << exp_w) - 64'd1) << frac_w) | (64'd1 << (frac_w - 1));
  endfunction

endpackage

// File: rtl/fpu_sched_rr_arb2.sv
// rtl/fpu_sched_rr_arb2.sv - combinational two-way round-robin grant
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt0,
  output logic gnt1
);

  // last_grant names the requester served most recently; the other one wins a tie.
  assign gnt0 = req0 && (!req1 || last_grant);
  assign gnt1 = req1 && (!req0 || !last_grant);

endmodule

// File: rtl/fpu_sched.sv
// rtl/fpu_sched.sv - round-robin sequencer around the shared FP add/sub/mul ALU
module fpu_sched
  import fpu_pkg::*;
#(
  parameter int EXP   = 8,
  parameter int FRAC  = 23,
  parameter int WIDTH = EXP + FRAC + 1,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req0_rnd,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  input  logic             req1_rnd,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [4:0]       rsp_flags,
  output logic [4:0]       sticky_flags,
  input  logic             sticky_clr,
  output logic             busy
);

  localparam int MW   = 2 * FRAC + 3;
  localparam int EMAX = (1 << EXP) - 1;
  localparam int BIAS = (1 << (EXP - 1)) - 1;
  localparam logic [WIDTH-1:0] QNAN_VAL = WIDTH'(qnan(EXP, FRAC));

  // Mantissa workspace: bit MW-2 is the units position, bit MW-1 catches carry-out.
  typedef logic [MW-1:0] wide_t;

  function automatic wide_t shr_sticky(input wide_t v, input int n);
    wide_t r;
    if (n <= 0) return v;
    if (n >= MW) return {{(MW-1){1'b0}}, |v};
    r = v >> n;
    r[0] = r[0] | (|(v & ~({MW{1'b1}} << n)));
    return r;
  endfunction

  // Normalise, round (rz=0 nearest-even, rz=1 toward zero) and pack; returns {flags, result}.
  function automatic logic [WIDTH+4:0] round_pack(input logic s, input int e_in,
                                                  input wide_t m_in, input logic rz);
    wide_t            m;
    int               e;
    logic [FRAC:0]    mant;
    logic [FRAC+1:0]  mr;
    logic             g, st, up, tiny;
    logic [4:0]       fl;
    logic [WIDTH-1:0] r;
    m  = m_in;
    e  = e_in;
    fl = '0;
    if (m == '0) return {5'b0, s, {(WIDTH-1){1'b0}}};
    if (m[MW-1]) begin
      m = shr_sticky(m, 1);
      e = e + 1;
    end
    for (int i = 0; i < MW; i++) begin
      if (!m[MW-2] && e > 1) begin
        m = m << 1;
        e = e - 1;
      end
    end
    if (e < 1) begin
      m = shr_sticky(m, 1 - e);
      e = 1;
    end
    mant = m[MW-2 -: FRAC+1];
    g    = m[FRAC];
    st   = |m[FRAC-1:0];
    tiny = !mant[FRAC];
    up   = !rz && g && (st || mant[0]);
    mr   = {1'b0, mant} + (FRAC+2)'(up);
    if (mr[FRAC+1]) begin
      mr = mr >> 1;
      e  = e + 1;
    end
    fl[FLG_NX] = g | st;
    fl[FLG_UF] = tiny & (g | st);
    if (e >= EMAX) begin
      fl[FLG_OF] = 1'b1;
      fl[FLG_NX] = 1'b1;
      r = rz ? {s, EXP'(EMAX - 1), {FRAC{1'b1}}} : {s, EXP'(EMAX), {FRAC{1'b0}}};
    end else begin
      r = {s, mr[FRAC] ? EXP'(e) : {EXP{1'b0}}, mr[FRAC-1:0]};
    end
    return {fl, r};
  endfunction

  function automatic logic [WIDTH+4:0] alu(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                           input logic [1:0] op, input logic rz);
    logic              sa, sb, ts;
    logic [EXP-1:0]    ea, eb;
    logic [FRAC-1:0]   fa, fb;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_snan, b_snan;
    int                xa, xb, tx;
    wide_t             ma, mb, mx, tm;
    logic [2*FRAC+1:0] ha, hb, p;
    {sa, ea, fa} = a;
    {sb, eb, fb} = b;
    if (op == OP_SUB) sb = !sb;
    a_nan  = (&ea) && (|fa);
    b_nan  = (&eb) && (|fb);
    a_inf  = (&ea) && !(|fa);
    b_inf  = (&eb) && !(|fb);
    a_zero = !(|ea) && !(|fa);
    b_zero = !(|eb) && !(|fb);
    a_snan = a_nan && !fa[FRAC-1];
    b_snan = b_nan && !fb[FRAC-1];
    xa = (|ea) ? int'(ea) : 1;
    xb = (|eb) ? int'(eb) : 1;
    // No divider in this datapath: div always reports invalid with a quiet NaN.
    if (op == OP_DIV) return {5'b10000, QNAN_VAL};
    if (a_nan || b_nan) return {(a_snan || b_snan) ? 5'b10000 : 5'b00000, QNAN_VAL};
    if (op == OP_MUL) begin
      if ((a_inf && b_zero) || (b_inf && a_zero)) return {5'b10000, QNAN_VAL};
      if (a_inf || b_inf) return {5'b0, sa ^ sb, {EXP{1'b1}}, {FRAC{1'b0}}};
      ha = {{(FRAC+1){1'b0}}, |ea, fa};
      hb = {{(FRAC+1){1'b0}}, |eb, fb};
      p  = ha * hb;
      return round_pack(sa ^ sb, xa + xb - BIAS, {p, 1'b0}, rz);
    end
    if (a_inf && b_inf && (sa != sb)) return {5'b10000, QNAN_VAL};
    if (a_inf) return {5'b0, sa, {EXP{1'b1}}, {FRAC{1'b0}}};
    if (b_inf) return {5'b0, sb, {EXP{1'b1}}, {FRAC{1'b0}}};
    ma = {1'b0, |ea, fa, {(FRAC+1){1'b0}}};
    mb = {1'b0, |eb, fb, {(FRAC+1){1'b0}}};
    if ({ea, fa} < {eb, fb}) begin
      ts = sa; sa = sb; sb = ts;
      tx = xa; xa = xb; xb = tx;
      tm = ma; ma = mb; mb = tm;
    end
    mb = shr_sticky(mb, xa - xb);
    if (sa == sb) return round_pack(sa, xa, ma + mb, rz);
    mx = ma - mb;
    return round_pack((mx == '0) ? 1'b0 : sa, xa, mx, rz);
  endfunction

  state_t           state, state_nxt;
  logic [3:0]       cnt;
  logic             last_grant;
  logic             gnt0, gnt1;
  logic [WIDTH-1:0] op_a, op_b;
  logic [1:0]       op_code;
  logic             op_rnd, op_id;
  logic [WIDTH-1:0] alu_res;
  logic [4:0]       alu_flg;
  logic             req_hs, rsp_hs;

  rr_arb2 u_arb (
    .req0       (req0_valid),
    .req1       (req1_valid),
    .last_grant (last_grant),
    .gnt0       (gnt0),
    .gnt1       (gnt1)
  );

  assign req0_ready = (state == S_IDLE) && gnt0;
  assign req1_ready = (state == S_IDLE) && gnt1;
  assign req_hs     = req0_ready || req1_ready;
  assign rsp_valid  = (state == S_RESP);
  assign rsp_hs     = rsp_valid && rsp_ready;
  assign busy       = (state != S_IDLE);

  assign {alu_flg, alu_res} = alu(op_a, op_b, op_code, op_rnd);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_hs) state_nxt = S_EXEC;
      S_EXEC:  if (cnt == '0) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      last_grant   <= 1'b1;
      op_a         <= '0;
      op_b         <= '0;
      op_code      <= OP_ADD;
      op_rnd       <= 1'b0;
      op_id        <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_flags    <= '0;
      sticky_flags <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && req_hs) begin
        op_a       <= gnt1 ? req1_a   : req0_a;
        op_b       <= gnt1 ? req1_b   : req0_b;
        op_code    <= gnt1 ? req1_op  : req0_op;
        op_rnd     <= gnt1 ? req1_rnd : req0_rnd;
        op_id      <= gnt1;
        last_grant <= gnt1;
        cnt        <= 4'(LAT - 1);
      end
      if (state == S_EXEC) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          rsp_result <= alu_res;
          rsp_flags  <= alu_flg;
          rsp_id     <= op_id;
        end
      end
      // A clear coinciding with a delivery keeps only the newly delivered flags.
      if (sticky_clr) sticky_flags <= rsp_hs ? rsp_flags : 5'b0;
      else if (rsp_hs) sticky_flags <= sticky_flags | rsp_flags;
    end
  end

endmodule

// File: tb/tb_fpu_sched.sv
// tb/tb_fpu_sched.sv - directed self-checking bench for fpu_sched
module tb_fpu_sched;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_rnd;
  logic [31:0] req0_a, req0_b;
  logic [1:0]  req0_op;
  logic        req1_valid, req1_ready, req1_rnd;
  logic [31:0] req1_a, req1_b;
  logic [1:0]  req1_op;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_flags, sticky_flags;
  logic        sticky_clr, busy;

  int n_checks = 0;
  int n_fail   = 0;

  fpu_sched #(.EXP(8), .FRAC(23), .LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_rnd(req0_rnd),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_rnd(req1_rnd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .sticky_flags(sticky_flags), .sticky_clr(sticky_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b0; sticky_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Drives one request on port id starting at a negedge; returns at the negedge after its handshake.
  task automatic send(input logic id, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic rnd);
    int k;
    if (id) begin
      req1_a = a; req1_b = b; req1_op = op; req1_rnd = rnd; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_op = op; req0_rnd = rnd; req0_valid = 1'b1;
    end
    k = 0;
    #1;
    while (!(id ? req1_ready : req0_ready) && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_checks++;
    if (!(id ? req1_ready : req0_ready)) begin
      n_fail++;
      $display("FAIL send_timeout: req%0d_ready got 0 required 1", id);
    end
    @(negedge clk);
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!rsp_valid) cyc = -1;
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({rsp_valid, rsp_id, busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 000", {rsp_valid, rsp_id, busy});
    end
    n_checks++;
    if (rsp_result !== 32'h0) begin
      n_fail++; $display("FAIL reset_result: got %h required 00000000", rsp_result);
    end
    n_checks++;
    if ({rsp_flags, sticky_flags} !== 10'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b required 0", {rsp_flags, sticky_flags});
    end
  endtask

  task automatic test_add();
    int cyc;
    send(1'b0, 32'h3F800000, 32'h40000000, OP_ADD, 1'b0);
    n_checks++;
    if ({busy, rsp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL add_exec: busy,rsp_valid got %b required 10", {busy, rsp_valid});
    end
    wait_rsp(cyc);
    n_checks++;
    if (cyc !== 2) begin
      n_fail++; $display("FAIL add_latency: got %0d required 2", cyc);
    end
    n_checks++;
    if (rsp_result !== 32'h40400000) begin
      n_fail++; $display("FAIL add_result: got %h required 40400000", rsp_result);
    end
    n_checks++;
    if ({rsp_id, rsp_flags} !== 6'b0) begin
      n_fail++; $display("FAIL add_id_flags: got %b required 000000", {rsp_id, rsp_flags});
    end
    take();
    n_checks++;
    if ({busy, rsp_valid} !== 2'b00) begin
      n_fail++; $display("FAIL add_idle: busy,rsp_valid got %b required 00", {busy, rsp_valid});
    end
  endtask

  task automatic test_simultaneous();
    int cyc;
    apply_reset();
    for (int pass = 0; pass < 2; pass++) begin
      req1_a = 32'h40000000; req1_b = 32'h40000000; req1_op = OP_MUL; req1_rnd = 1'b0;
      req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_op = OP_ADD; req0_rnd = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
        n_fail++; $display("FAIL sim_grant0_pass%0d: got %b required 10", pass, {req0_ready, req1_ready});
      end
      @(negedge clk);
      req0_valid = 1'b0;
      wait_rsp(cyc);
      n_checks++;
      if ({cyc == 2, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'h40400000}) begin
        n_fail++; $display("FAIL sim_rsp0_pass%0d: lat %0d id %b result %h required lat 2 id 0 result 40400000",
                           pass, cyc, rsp_id, rsp_result);
      end
      take();
      #1;
      n_checks++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
        n_fail++; $display("FAIL sim_grant1_pass%0d: got %b required 01", pass, {req0_ready, req1_ready});
      end
      @(negedge clk);
      req1_valid = 1'b0;
      wait_rsp(cyc);
      n_checks++;
      if ({cyc == 2, rsp_id, rsp_result} !== {1'b1, 1'b1, 32'h40800000}) begin
        n_fail++; $display("FAIL sim_rsp1_pass%0d: lat %0d id %b result %h required lat 2 id 1 result 40800000",
                           pass, cyc, rsp_id, rsp_result);
      end
      take();
    end
  endtask

  task automatic test_overflow();
    int cyc;
    send(1'b1, 32'h7F7FFFFF, 32'h40000000, OP_MUL, 1'b0);
    wait_rsp(cyc);
    n_checks++;
    if ({rsp_id, rsp_result, rsp_flags} !== {1'b1, 32'h7F800000, 5'b00101}) begin
      n_fail++; $display("FAIL ovf_rne: id %b result %h flags %b required 1 7f800000 00101",
                         rsp_id, rsp_result, rsp_flags);
    end
    take();
    n_checks++;
    if (sticky_flags !== 5'b00101) begin
      n_fail++; $display("FAIL ovf_sticky: got %b required 00101", sticky_flags);
    end
    send(1'b1, 32'h7F7FFFFF, 32'h40000000, OP_MUL, 1'b1);
    wait_rsp(cyc);
    n_checks++;
    if ({rsp_result, rsp_flags} !== {32'h7F7FFFFF, 5'b00101}) begin
      n_fail++; $display("FAIL ovf_rz: result %h flags %b required 7f7fffff 00101", rsp_result, rsp_flags);
    end
    take();
  endtask

  task automatic test_div_clear();
    int cyc;
    send(1'b0, 32'h3F800000, 32'h40000000, OP_DIV, 1'b0);
    wait_rsp(cyc);
    n_checks++;
    if ({cyc == 2, rsp_result, rsp_flags} !== {1'b1, 32'h7FC00000, 5'b10000}) begin
      n_fail++; $display("FAIL div_rsp: lat %0d result %h flags %b required lat 2 7fc00000 10000",
                         cyc, rsp_result, rsp_flags);
    end
    rsp_ready = 1'b1; sticky_clr = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; sticky_clr = 1'b0;
    n_checks++;
    if (sticky_flags !== 5'b10000) begin
      n_fail++; $display("FAIL clr_with_hs: got %b required 10000", sticky_flags);
    end
    send(1'b0, 32'h40400000, 32'h3F800000, OP_SUB, 1'b0);
    wait_rsp(cyc);
    n_checks++;
    if ({rsp_result, rsp_flags} !== {32'h40000000, 5'b00000}) begin
      n_fail++; $display("FAIL sub_rsp: result %h flags %b required 40000000 00000", rsp_result, rsp_flags);
    end
    take();
    send(1'b0, 32'h3F800000, 32'h33800000, OP_ADD, 1'b0);
    wait_rsp(cyc);
    n_checks++;
    if ({rsp_result, rsp_flags} !== {32'h3F800000, 5'b00001}) begin
      n_fail++; $display("FAIL tie_even: result %h flags %b required 3f800000 00001", rsp_result, rsp_flags);
    end
    take();
    n_checks++;
    if (sticky_flags !== 5'b10001) begin
      n_fail++; $display("FAIL sticky_accum: got %b required 10001", sticky_flags);
    end
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    n_checks++;
    if (sticky_flags !== 5'b00000) begin
      n_fail++; $display("FAIL clr_alone: got %b required 00000", sticky_flags);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    send(1'b1, 32'h3FC00000, 32'h3FC00000, OP_MUL, 1'b0);
    wait_rsp(cyc);
    req0_a = 32'h12345678; req0_op = OP_SUB; req0_valid = 1'b1;
    req1_a = 32'h0BADBEEF; req1_op = OP_ADD; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_flags} !== {1'b1, 1'b1, 32'h40100000, 5'b00000}) begin
        n_fail++; $display("FAIL bp_hold_%0d: valid %b id %b result %h flags %b required 1 1 40100000 00000",
                           i, rsp_valid, rsp_id, rsp_result, rsp_flags);
      end
      n_checks++;
      if ({req0_ready, req1_ready, busy} !== 3'b001) begin
        n_fail++; $display("FAIL bp_ready_%0d: got %b required 001", i, {req0_ready, req1_ready, busy});
      end
    end
    take();
    n_checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL bp_release: rsp_valid,busy got %b required 00", {rsp_valid, busy});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++;
    if (sticky_flags !== 5'b00000) begin
      n_fail++; $display("FAIL bp_sticky: got %b required 00000", sticky_flags);
    end
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    int seen;
    send(1'b0, 32'h7F7FFFFF, 32'h40000000, OP_MUL, 1'b0);
    wait_rsp(cyc);
    take();
    n_checks++;
    if (sticky_flags !== 5'b00101) begin
      n_fail++; $display("FAIL rmo_pre_sticky: got %b required 00101", sticky_flags);
    end
    send(1'b0, 32'h3F800000, 32'h40000000, OP_ADD, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL rmo_async: rsp_valid,busy got %b required 00", {rsp_valid, busy});
    end
    n_checks++;
    if ({sticky_flags, rsp_result} !== 37'b0) begin
      n_fail++; $display("FAIL rmo_clear: sticky %b result %h required 0 0", sticky_flags, rsp_result);
    end
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    rsp_ready = 1'b0;
    n_checks++;
    if (seen !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rmo_no_rsp: responses %0d busy %b required 0 0", seen, busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = OP_ADD; req0_rnd = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = OP_ADD; req1_rnd = 1'b0;
    rsp_ready = 1'b0; sticky_clr = 1'b0;
    test_reset();
    test_add();
    test_simultaneous();
    test_overflow();
    test_div_clear();
    test_backpressure();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
